// File: rtl/motor_pkg.sv
// Shared codes for the line-tracker -> motor-drive path: steering states,
// supervisor modes and H-bridge direction encodings.
package motor_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned DIR_W   = 2;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_TURN_LEFT   = 3'b000,
    ST_TURN_RIGHT  = 3'b001,
    ST_STRAIGHT    = 3'b010,
    ST_STOP        = 3'b011,
    ST_SHARP_LEFT  = 3'b100,
    ST_SHARP_RIGHT = 3'b101
  } steer_t;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_SEARCH = 2'd2,
    MODE_HALT   = 2'd3
  } mode_t;

  typedef enum logic [DIR_W-1:0] {
    DIR_COAST = 2'b00,
    DIR_REV   = 2'b01,
    DIR_FWD   = 2'b10
  } dir_t;

  typedef enum logic {
    TURN_LEFT  = 1'b0,
    TURN_RIGHT = 1'b1
  } turn_t;

  // Codes 110/111 are undefined on the bus and are read as stop.
  function automatic logic is_stop(input logic [STATE_W-1:0] s);
    return (s == ST_STOP) || (s[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One wheel: duty/direction ramp updated at PWM boundaries, plus the PWM compare.
module motor_channel
  import motor_pkg::*;
#(
  parameter int unsigned PWM_W     = 10,
  parameter int unsigned RAMP_STEP = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PWM_W-1:0] cnt,
  input  logic             tick,
  input  logic [PWM_W-1:0] tgt_duty,
  input  logic [DIR_W-1:0] tgt_dir,
  output logic             pwm,
  output logic [DIR_W-1:0] dir
);

  localparam logic [PWM_W-1:0] STEP = PWM_W'(RAMP_STEP);

  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] duty_nxt;
  logic [DIR_W-1:0] dir_nxt;

  // Reversal ramps down first; the direction flips only once duty reaches zero.
  always_comb begin
    duty_nxt = duty;
    dir_nxt  = dir;
    if (tick) begin
      if (dir != tgt_dir) begin
        if (duty > STEP) begin
          duty_nxt = duty - STEP;
        end else begin
          duty_nxt = '0;
          dir_nxt  = tgt_dir;
        end
      end else if (duty < tgt_duty) begin
        duty_nxt = ((tgt_duty - duty) > STEP) ? duty + STEP : tgt_duty;
      end else if (duty > tgt_duty) begin
        duty_nxt = ((duty - tgt_duty) > STEP) ? duty - STEP : tgt_duty;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty <= '0;
      dir  <= DIR_COAST;
      pwm  <= 1'b0;
    end else begin
      duty <= duty_nxt;
      dir  <= dir_nxt;
      pwm  <= (cnt < duty);
    end
  end

endmodule

// File: rtl/motor_drive.sv
// Steering-state decoder, lost-line supervisor and two ramped H-bridge channels.
module motor_drive
  import motor_pkg::*;
#(
  parameter int unsigned PWM_W         = 10,
  parameter int unsigned DUTY_FAST     = 800,
  parameter int unsigned DUTY_SLOW     = 400,
  parameter int unsigned DUTY_SHARP    = 500,
  parameter int unsigned RAMP_STEP     = 100,
  parameter int unsigned LOST_CYCLES   = 5_000_000,
  parameter int unsigned SEARCH_CYCLES = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  input  logic               start,
  output logic               left_pwm,
  output logic               right_pwm,
  output logic [DIR_W-1:0]   left_dir,
  output logic [DIR_W-1:0]   right_dir,
  output logic [MODE_W-1:0]  mode
);

  localparam logic [PWM_W-1:0] FAST_D  = PWM_W'(DUTY_FAST);
  localparam logic [PWM_W-1:0] SLOW_D  = PWM_W'(DUTY_SLOW);
  localparam logic [PWM_W-1:0] SHARP_D = PWM_W'(DUTY_SHARP);
  localparam logic [CNT_W-1:0] LOST_LAST   = CNT_W'(LOST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_CYCLES - 1);

  mode_t            mode_q, mode_nxt;
  logic [CNT_W-1:0] stop_cnt, stop_cnt_nxt;
  logic [CNT_W-1:0] search_cnt, search_cnt_nxt;
  turn_t            last_turn, last_turn_nxt;
  logic [PWM_W-1:0] cnt;
  logic             tick;
  logic [PWM_W-1:0] l_duty, r_duty;
  logic [DIR_W-1:0] l_dir, r_dir;

  assign tick = &cnt;
  assign mode = mode_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= MODE_IDLE;
      stop_cnt   <= '0;
      search_cnt <= '0;
      last_turn  <= TURN_LEFT;
      cnt        <= '0;
    end else begin
      mode_q     <= mode_nxt;
      stop_cnt   <= stop_cnt_nxt;
      search_cnt <= search_cnt_nxt;
      last_turn  <= last_turn_nxt;
      cnt        <= cnt + PWM_W'(1);
    end
  end

  // Supervisor: lost-line detection, bounded search, halt.
  always_comb begin
    mode_nxt       = mode_q;
    stop_cnt_nxt   = stop_cnt;
    search_cnt_nxt = '0;
    last_turn_nxt  = last_turn;
    unique case (mode_q)
      MODE_IDLE, MODE_HALT: begin
        stop_cnt_nxt = '0;
        if (start) mode_nxt = MODE_RUN;
      end
      MODE_RUN: begin
        if (is_stop(state)) begin
          if (stop_cnt == LOST_LAST) begin
            mode_nxt     = MODE_SEARCH;
            stop_cnt_nxt = '0;
          end else begin
            stop_cnt_nxt = stop_cnt + CNT_W'(1);
          end
        end else begin
          stop_cnt_nxt = '0;
        end
        if (state == ST_TURN_LEFT || state == ST_SHARP_LEFT) last_turn_nxt = TURN_LEFT;
        if (state == ST_TURN_RIGHT || state == ST_SHARP_RIGHT) last_turn_nxt = TURN_RIGHT;
      end
      MODE_SEARCH: begin
        stop_cnt_nxt = '0;
        if (!is_stop(state)) begin
          mode_nxt = MODE_RUN;
        end else if (search_cnt == SEARCH_LAST) begin
          mode_nxt = MODE_HALT;
        end else begin
          search_cnt_nxt = search_cnt + CNT_W'(1);
        end
      end
      default: mode_nxt = MODE_IDLE;
    endcase
  end

  // Wheel targets; a zero target keeps the current direction to avoid needless flips.
  always_comb begin
    l_duty = '0;
    r_duty = '0;
    l_dir  = left_dir;
    r_dir  = right_dir;
    if (mode_q == MODE_RUN) begin
      case (state)
        ST_STRAIGHT:    begin l_duty = FAST_D;  l_dir = DIR_FWD; r_duty = FAST_D;  r_dir = DIR_FWD; end
        ST_TURN_LEFT:   begin l_duty = SLOW_D;  l_dir = DIR_FWD; r_duty = FAST_D;  r_dir = DIR_FWD; end
        ST_TURN_RIGHT:  begin l_duty = FAST_D;  l_dir = DIR_FWD; r_duty = SLOW_D;  r_dir = DIR_FWD; end
        ST_SHARP_LEFT:  begin l_duty = SHARP_D; l_dir = DIR_REV; r_duty = FAST_D;  r_dir = DIR_FWD; end
        ST_SHARP_RIGHT: begin l_duty = FAST_D;  l_dir = DIR_FWD; r_duty = SHARP_D; r_dir = DIR_REV; end
        default: ;
      endcase
    end else if (mode_q == MODE_SEARCH) begin
      l_duty = SLOW_D;
      r_duty = SLOW_D;
      if (last_turn == TURN_LEFT) begin
        l_dir = DIR_REV;
        r_dir = DIR_FWD;
      end else begin
        l_dir = DIR_FWD;
        r_dir = DIR_REV;
      end
    end
  end

  motor_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_left (
    .clk      (clk),
    .reset    (reset),
    .cnt      (cnt),
    .tick     (tick),
    .tgt_duty (l_duty),
    .tgt_dir  (l_dir),
    .pwm      (left_pwm),
    .dir      (left_dir)
  );

  motor_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_right (
    .clk      (clk),
    .reset    (reset),
    .cnt      (cnt),
    .tick     (tick),
    .tgt_duty (r_duty),
    .tgt_dir  (r_dir),
    .pwm      (right_pwm),
    .dir      (right_dir)
  );

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with a 16-cycle PWM period; duty is measured
// as the count of pwm-high cycles over one full period.
module tb_motor_drive;

  logic       clk;
  logic       reset;
  logic [2:0] state;
  logic       start;
  logic       left_pwm, right_pwm;
  logic [1:0] left_dir, right_dir;
  logic [1:0] mode;

  int vectors     = 0;
  int miscompares = 0;

  motor_drive #(
    .PWM_W(4), .DUTY_FAST(12), .DUTY_SLOW(6), .DUTY_SHARP(8),
    .RAMP_STEP(4), .LOST_CYCLES(20), .SEARCH_CYCLES(64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .start     (start),
    .left_pwm  (left_pwm),
    .right_pwm (right_pwm),
    .left_dir  (left_dir),
    .right_dir (right_dir),
    .mode      (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call right after a boundary edge; counts highs for the duty set at that edge.
  task automatic measure(input string tag, input int exp_l, input int exp_r);
    int hl = 0;
    int hr = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      hl += int'(left_pwm);
      hr += int'(right_pwm);
    end
    check({tag, " left duty"}, hl, exp_l);
    check({tag, " right duty"}, hr, exp_r);
  endtask

  initial begin
    int exp_b [6];
    reset = 1'b1;
    start = 1'b0;
    state = 3'b000;
    #1 reset = 1'b0;
    #2;
    check("reset left_pwm", int'(left_pwm), 0);
    check("reset right_pwm", int'(right_pwm), 0);
    check("reset left_dir", int'(left_dir), 0);
    check("reset right_dir", int'(right_dir), 0);
    check("reset mode", int'(mode), 0);

    // Start straight; first boundary only sets direction, then 4/8/12.
    start = 1'b1;
    state = 3'b010;
    #9 reset = 1'b1;
    step(1);
    check("start mode run", int'(mode), 1);
    start = 1'b0;
    step(14);
    check("pre-boundary left_dir", int'(left_dir), 0);
    step(1);
    check("first boundary left_dir", int'(left_dir), 2);
    check("first boundary right_dir", int'(right_dir), 2);
    measure("ramp p0", 0, 0);
    measure("ramp p1", 4, 4);
    measure("ramp p2", 8, 8);
    measure("ramp p3", 12, 12);
    measure("ramp p4", 12, 12);
    check("straight mode", int'(mode), 1);

    // Sharp left: left ramps down, flips to reverse at zero, ramps back up to 8.
    state = 3'b100;
    exp_b = '{12, 8, 4, 0, 4, 8};
    for (int i = 0; i < 6; i++) begin
      measure($sformatf("sharp p%0d", i), exp_b[i], 12);
      if (i == 1) check("sharp left_dir still fwd", int'(left_dir), 2);
      if (i == 2) check("sharp left_dir rev", int'(left_dir), 1);
    end
    check("sharp right_dir", int'(right_dir), 2);

    // Lost-line counting after a right turn.
    state = 3'b001;
    step(1);
    state = 3'b011;
    step(19);
    check("19 stops mode", int'(mode), 1);
    state = 3'b001;
    step(1);
    state = 3'b011;
    step(19);
    check("19 stops again mode", int'(mode), 1);
    step(1);
    check("20 stops mode search", int'(mode), 2);
    step(7);
    check("search left_dir fwd", int'(left_dir), 2);
    check("search right_dir rev", int'(right_dir), 1);
    step(16);
    measure("search p0", 4, 4);
    measure("search p1", 6, 6);
    step(8);
    check("search 63 cycles mode", int'(mode), 2);
    step(1);
    check("search 64 cycles halt", int'(mode), 3);

    // HALT ignores state and ramps both wheels to zero.
    state = 3'b010;
    step(7);
    measure("halt p0", 2, 2);
    measure("halt p1", 0, 0);
    check("halt ignores state", int'(mode), 3);
    check("halt left_dir kept", int'(left_dir), 2);
    check("halt right_dir kept", int'(right_dir), 1);
    start = 1'b1;
    step(1);
    check("start from halt", int'(mode), 1);
    start = 1'b0;

    // Code 110 counts as stop; a non-stop sample leaves search.
    state = 3'b110;
    step(19);
    check("110 x19 mode", int'(mode), 1);
    step(1);
    check("110 x20 mode search", int'(mode), 2);
    state = 3'b010;
    step(1);
    check("search exit to run", int'(mode), 1);
    step(3);
    check("pre-reset left_dir", int'(left_dir), 2);
    check("pre-reset right_dir", int'(right_dir), 1);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    check("async reset left_dir", int'(left_dir), 0);
    check("async reset right_dir", int'(right_dir), 0);
    check("async reset left_pwm", int'(left_pwm), 0);
    check("async reset mode", int'(mode), 0);
    #3 reset = 1'b1;
    step(1);
    check("post-reset mode idle", int'(mode), 0);
    step(15);
    measure("post-reset", 0, 0);
    check("post-reset left_dir", int'(left_dir), 0);
    check("post-reset right_dir", int'(right_dir), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
